// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time loader for a small RISC-V instruction memory. On a legal start
//   it first overwrites every word of the memory with NOP_WORD, then receives
//   the program as a little-endian byte stream and writes it word by word
//   from address 0. The core is held in reset-like suspension (cpu_hold)
//   for the whole load.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a load (honoured only in IDLE or DONE)
//   word_count        number of words to load, legal 1 .. 2**ADDR_W
//   byte_valid/data   incoming program byte stream
//   byte_ready        loader accepts a byte this cycle
//   wr_en/addr/data   instruction-memory write port
//   cpu_hold          core must not fetch while high
//   done              last load completed
//   err               last start carried an illegal word_count
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         asm_q, asm_d;
  logic                byte_ready_q, byte_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Next-state logic. word_idx doubles as the CLEAR address counter: it runs
  // 0..2**ADDR_W-1 during CLEAR and wraps back to 0 as RECV is entered, which
  // is exactly the first program word index.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    err_d      = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (word_count == '0 || word_count > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d      = 1'b0;
            count_d    = word_count;
            word_idx_d = '0;
            byte_cnt_d = 2'd0;
            asm_d      = 32'd0;
            state_d    = CLEAR;
          end
        end
      end
      CLEAR: begin
        word_idx_d = word_idx_q + IDX_ONE;
        if (word_idx_q == '1) state_d = RECV;
      end
      RECV: begin
        if (byte_valid && byte_ready_q) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if ({1'b0, word_idx_q} == count_q - COUNT_ONE) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + IDX_ONE;
          state_d    = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    byte_ready_d = (state_d == RECV);
    wr_en_d      = (state_d == CLEAR) || (state_d == WRITE);
    cpu_hold_d   = (state_d == CLEAR) || (state_d == RECV) || (state_d == WRITE);
    done_d       = (state_d == DONE);
    wr_addr_d    = '0;
    wr_data_d    = 32'd0;
    if (state_d == CLEAR) begin
      wr_addr_d = word_idx_d;
      wr_data_d = NOP_WORD;
    end else if (state_d == WRITE) begin
      wr_addr_d = word_idx_d;
      wr_data_d = asm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboard bench for imem_loader. Each load pushes the complete expected
//   write sequence (NOP fill, then the program words assembled from the byte
//   list) into a queue; an independent monitor pops and compares on every
//   observed write.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          ADDR_W = 6;
  localparam int          WORDS  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W+31:0] sb_q[$];
  logic [ADDR_W+31:0] mon_exp;
  logic               mon_present;

  imem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled on the
  // falling edge so nothing races the active edge.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: a load writes NOP to every address in order, then each
  // program word, built little-endian from four consecutive bytes.
  task automatic expectLoad(input int count, input logic [7:0] bytes[$]);
    for (int a = 0; a < WORDS; a++)
      sb_q.push_back({ADDR_W'(a), NOP});
    for (int w = 0; w < count; w++)
      sb_q.push_back({ADDR_W'(w), bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});
  endtask

  // Monitor: every write the DUT issues must be the next one the model
  // predicted, and the loader must never offer to take bytes while writing.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      mon_present = (sb_q.size() != 0);
      checkOutput("write_expected", {31'd0, mon_present}, 32'd1);
      if (mon_present) begin
        mon_exp = sb_q.pop_front();
        checkOutput("wr_addr", {26'd0, wr_addr}, {26'd0, mon_exp[ADDR_W+31:32]});
        checkOutput("wr_data", wr_data, mon_exp[31:0]);
      end
      checkOutput("byte_ready_during_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic checkAllZero(input string name);
    checkOutput(name, {21'd0, byte_ready, wr_en, cpu_hold, done, err, wr_addr}, 32'd0);
    checkOutput({name, "_data"}, wr_data, 32'd0);
  endtask

  // Called right after a falling edge: pulse a legal start for one cycle.
  task automatic issueStart(input int count);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(count);
    @(negedge clk);
    start = 1'b0;
    checkOutput("cpu_hold_after_start", {31'd0, cpu_hold}, 32'd1);
    checkOutput("err_after_start", {31'd0, err}, 32'd0);
    checkOutput("done_after_start", {31'd0, done}, 32'd0);
  endtask

  task automatic startIllegal(input int count);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(count);
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_illegal", {31'd0, err}, 32'd1);
    checkOutput("done_illegal", {31'd0, done}, 32'd0);
    checkOutput("cpu_hold_illegal", {31'd0, cpu_hold}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("wr_en_illegal", {31'd0, wr_en}, 32'd0);
    end
  endtask

  // Offer each byte, holding it until the loader takes it, with a random idle
  // gap before it during which byte_data carries garbage.
  task automatic sendBytes(input logic [7:0] bytes[$], input int max_gap);
    int waits;
    for (int i = 0; i < bytes.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = bytes[i];
      waits = 0;
      while (!byte_ready && waits < 200) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 200) begin
        checkOutput("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic waitDone();
    int waits = 0;
    while (!done && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("done_rise", {31'd0, done}, 32'd1);
    checkOutput("cpu_hold_at_done", {31'd0, cpu_hold}, 32'd0);
    checkOutput("sb_drained", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("done_hold", {31'd0, done}, 32'd1);
  endtask

  task automatic applyStimulus(input int count, input logic [7:0] bytes[$],
                               input int max_gap);
    expectLoad(count, bytes);
    issueStart(count);
    sendBytes(bytes, max_gap);
    waitDone();
  endtask

  // Watchdog so a stuck DUT still produces a verdict.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    logic [7:0] prog[$];
    logic [7:0] rnd[$];
    int         n;

    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;

    #12;
    checkAllZero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("idle_outputs");

    $display("[TB] two-word program, no gaps");
    prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
    applyStimulus(2, prog, 0);

    $display("[TB] two-word program, random gaps");
    applyStimulus(2, prog, 3);

    $display("[TB] illegal counts");
    startIllegal(0);
    startIllegal(65);
    startIllegal(127);
    rnd = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(1, rnd, 2);

    $display("[TB] asynchronous reset during CLEAR");
    expectLoad(1, rnd);
    issueStart(1);
    repeat (10) @(negedge clk);
    checkOutput("wr_en_before_reset", {31'd0, wr_en}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset_outputs");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post_reset_idle");

    $display("[TB] reset after two bytes of word 1");
    expectLoad(2, prog);
    issueStart(2);
    sendBytes(prog[0:5], 1);
    repeat (2) @(negedge clk);
    checkOutput("sb_pending_before_abort", sb_q.size(), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("abort_reset_outputs");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    prog = '{8'h13, 8'h00, 8'h00, 8'h00};
    applyStimulus(1, prog, 0);

    $display("[TB] full 64-word program");
    rnd.delete();
    for (int w = 0; w < WORDS; w++) begin
      rnd.push_back(8'(w * 4));
      rnd.push_back(8'h00);
      rnd.push_back(8'h00);
      rnd.push_back(8'h00);
    end
    applyStimulus(WORDS, rnd, 1);

    $display("[TB] restart from DONE and random programs");
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(10, 1);
      rnd.delete();
      for (int b = 0; b < 4 * n; b++) rnd.push_back(8'($urandom));
      applyStimulus(n, rnd, 3);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width (64 words).
REQ-002 The module SHALL have parameter NOP_WORD, default 32'h00000013, giving the fill word ADDI x0,x0,0.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: begins a load; sampled only in IDLE or DONE.
REQ-006 The module SHALL have port word_count, input, ADDR_W+1 bits: number of words to load (legal 1..64); sampled on the accepted start cycle.
REQ-007 The module SHALL have port byte_valid, input, 1 bit: byte_data carries a program byte.
REQ-008 The module SHALL have port byte_data, input, 8 bits: program byte stream, little-endian within each word.
REQ-009 The module SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 The module SHALL have port wr_en, output, 1 bit: one-cycle write strobe to the instruction-memory write port.
REQ-011 The module SHALL have port wr_addr, output, ADDR_W bits: word address of the write.
REQ-012 The module SHALL have port wr_data, output, 32 bits: word to write.
REQ-013 The module SHALL have port cpu_hold, output, 1 bit: holds the core (PC and fetch) while a load is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: the last load completed successfully.
REQ-015 The module SHALL have port err, output, 1 bit: the last start carried an illegal word_count.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, CLEAR, RECV, WRITE and DONE.
REQ-017 In IDLE or DONE, start=1 with a legal word_count SHALL latch the count, clear done and err, and enter CLEAR on the next cycle.
REQ-018 In IDLE or DONE, start=1 with word_count of 0 or greater than 64 SHALL set err=1 and done=0 next cycle, enter IDLE, and issue no write.
REQ-019 In CLEAR, the block SHALL assert wr_en every cycle with wr_data=NOP_WORD and wr_addr running 0..63, one address per cycle (64 cycles), then enter RECV.
REQ-020 In RECV, byte_ready SHALL be 1; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-021 In RECV, accepted bytes SHALL fill the assembly register in order bits 7:0, 15:8, 23:16, 31:24.
REQ-022 Cycles with byte_valid=0 in RECV SHALL be ignored and SHALL NOT advance the byte counter.
REQ-023 On acceptance of the 4th byte of a word, the FSM SHALL enter WRITE.
REQ-024 In WRITE, byte_ready SHALL be 0, and wr_en=1 SHALL be asserted for exactly one cycle with wr_addr equal to the word index and wr_data equal to the assembled word.
REQ-025 From WRITE, the FSM SHALL go to DONE if the word index equals count-1; otherwise it SHALL increment the word index and return to RECV.
REQ-026 The word index SHALL never wrap: with count=64 the last write is to address 63, followed by DONE.
REQ-027 In DONE, done=1 SHALL hold until the next accepted start.
REQ-028 cpu_hold SHALL be 1 exactly while in CLEAR, RECV or WRITE, and SHALL fall in the same cycle done rises.
REQ-029 In IDLE and DONE, wr_en=0 and byte_ready=0 SHALL hold, and start SHALL be ignored in CLEAR, RECV and WRITE.
REQ-030 Outside wr_en cycles, wr_addr and wr_data SHALL be don't-care but stable; the implementation SHALL drive 0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and set byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done and err to 0, and clear the byte counter, word index, latched count and assembly register.
REQ-032 A reset during any state SHALL abort the load with no further writes, and a subsequent start SHALL perform a complete fresh load including CLEAR.

Verification
REQ-033 Assert rst_n=0 mid-cycle -> all outputs 0 without waiting for a clock edge; release rst_n -> state IDLE.
REQ-034 Apply start with count=2 and bytes 93 00 50 00 13 01 50 00 -> 64 NOP writes to addresses 0..63, then writes 00500093 to address 0 and 00500113 to address 1; done=1 and cpu_hold=0 together.
REQ-035 Repeat the previous scenario with byte_valid gaps of 0-3 random cycles -> identical write sequence, with no write while byte_valid=0.
REQ-036 Apply start with count=0, and separately with count=65 -> err=1 next cycle, no wr_en, cpu_hold stays 0, then a legal start clears err.
REQ-037 Assert reset after 2 bytes of word 1, then apply start with count=1 and bytes 13 00 00 00 -> address 0 receives 00000013 with no stale byte merged.
REQ-038 Apply start with count=64 and the word stream addr*4 -> last write is address 63 with data 000000FC, no write to address 0 after CLEAR except word 0, done asserts, and start in DONE restarts cleanly.
